// File: rtl/interrupt_sequencer_pkg.sv
// rtl/interrupt_sequencer_pkg.sv - shared states, cause/push codes and default vectors for interrupt_sequencer
package interrupt_sequencer_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DUMMY1,
    S_DUMMY2,
    S_PUSH_PCH,
    S_PUSH_PCL,
    S_PUSH_P,
    S_VEC_LO,
    S_VEC_HI,
    S_DONE
  } state_t;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_RES  = 2'd1;
  localparam logic [1:0] CAUSE_NMI  = 2'd2;
  localparam logic [1:0] CAUSE_IRQ  = 2'd3;

  localparam logic [1:0] PUSH_NONE = 2'b00;
  localparam logic [1:0] PUSH_PCH  = 2'b01;
  localparam logic [1:0] PUSH_PCL  = 2'b10;
  localparam logic [1:0] PUSH_P    = 2'b11;

  localparam logic [7:0]  DEF_STACK_PAGE = 8'h01;
  localparam logic [15:0] DEF_VEC_NMI    = 16'hFFFA;
  localparam logic [15:0] DEF_VEC_RES    = 16'hFFFC;
  localparam logic [15:0] DEF_VEC_IRQ    = 16'hFFFE;

endpackage

// File: rtl/interrupt_sequencer_irq_priority_encoder.sv
// rtl/interrupt_sequencer_irq_priority_encoder.sv - masked lowest-index select over the maskable IRQ lines
module irq_priority_encoder #(
  parameter int NUM_IRQ = 1
) (
  input  logic [NUM_IRQ-1:0] req,
  input  logic               enable,
  output logic               valid,
  output logic [3:0]         index
);

  // Scan from the top down so the lowest asserted index is the last one written.
  always_comb begin
    valid = 1'b0;
    index = 4'd0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (enable && req[k]) begin
        valid = 1'b1;
        index = 4'(k);
      end
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// rtl/interrupt_sequencer.sv - RES/NMI/IRQ/BRK entry sequencer; IRQ_VECTOR_TABLE_EN gives each IRQ source its own vector
module interrupt_sequencer
  import interrupt_sequencer_pkg::*;
#(
  parameter int          ADDR_W     = 16,
  parameter int          NUM_IRQ    = 1,
  parameter logic [7:0]  STACK_PAGE = DEF_STACK_PAGE,
  parameter logic [15:0] VEC_NMI    = DEF_VEC_NMI,
  parameter logic [15:0] VEC_RES    = DEF_VEC_RES,
  parameter logic [15:0] VEC_IRQ    = DEF_VEC_IRQ
) (
  input  logic               clk,
  input  logic               res,
  input  logic               rdy,
  input  logic               sync,
  input  logic               brk,
  input  logic               nmi,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               i_flag,
  input  logic [7:0]         sp,
  input  logic [7:0]         data_in,
  output logic               busy,
  output logic [ADDR_W-1:0]  memory_address,
  output logic [1:0]         address_select,
  output logic               rw,
  output logic [1:0]         push_sel,
  output logic               sp_dec,
  output logic               pc_load,
  output logic [ADDR_W-1:0]  pc_value,
  output logic               set_i,
  output logic               b_flag,
  output logic [1:0]         cause,
  output logic [3:0]         irq_id
);

  state_t              state;
  logic                reset_pending;
  logic                nmi_latch;
  logic                nmi_prev;
  logic                is_brk;
  logic [ADDR_W-1:0]   vec_addr;
  logic [7:0]          vec_lo;

  logic                irq_valid;
  logic [3:0]          irq_index;
  logic                hijack;
  logic [7:0]          stack_sp;
  logic [ADDR_W-1:0]   stack_addr;
  logic [ADDR_W-1:0]   vec_next;

  irq_priority_encoder #(.NUM_IRQ(NUM_IRQ)) u_prio (
    .req    (irq),
    .enable (~i_flag),
    .valid  (irq_valid),
    .index  (irq_index)
  );

  // SP decrements on the same edge that loads the next push address, so look one ahead.
  assign stack_sp   = sp - {7'd0, sp_dec};
  assign stack_addr = ADDR_W'({STACK_PAGE, stack_sp});
  assign hijack     = (cause == CAUSE_IRQ) && nmi_latch;

  always_comb begin
    vec_next = ADDR_W'(VEC_IRQ);
    if (cause == CAUSE_RES)
      vec_next = ADDR_W'(VEC_RES);
    else if (cause == CAUSE_NMI || hijack)
      vec_next = ADDR_W'(VEC_NMI);
`ifdef IRQ_VECTOR_TABLE_EN
    else if (!is_brk)
      vec_next = ADDR_W'(VEC_IRQ) - ADDR_W'({irq_id, 1'b0}) - ADDR_W'(2);
`else
`endif
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state          <= S_IDLE;
      reset_pending  <= 1'b1;
      nmi_latch      <= 1'b0;
      nmi_prev       <= 1'b0;
      is_brk         <= 1'b0;
      vec_addr       <= '0;
      vec_lo         <= 8'd0;
      busy           <= 1'b1;
      memory_address <= '0;
      address_select <= 2'd0;
      rw             <= 1'b1;
      push_sel       <= PUSH_NONE;
      sp_dec         <= 1'b0;
      pc_load        <= 1'b0;
      pc_value       <= '0;
      set_i          <= 1'b0;
      b_flag         <= 1'b0;
      cause          <= CAUSE_RES;
      irq_id         <= 4'd0;
    end else begin
      // The edge detector keeps running while rdy is low.
      nmi_prev <= nmi;
      if (nmi && !nmi_prev)
        nmi_latch <= 1'b1;
      else if (rdy && state == S_VEC_LO && cause == CAUSE_NMI)
        nmi_latch <= 1'b0;

      if (rdy) begin
        pc_load        <= 1'b0;
        set_i          <= 1'b0;
        b_flag         <= 1'b0;
        sp_dec         <= 1'b0;
        push_sel       <= PUSH_NONE;
        rw             <= 1'b1;
        address_select <= 2'd0;

        case (state)
          S_IDLE: begin
            if (reset_pending) begin
              reset_pending <= 1'b0;
              state         <= S_DUMMY1;
              busy          <= 1'b1;
              cause         <= CAUSE_RES;
              irq_id        <= 4'd0;
              is_brk        <= 1'b0;
            end else if (sync && (nmi_latch || irq_valid || brk)) begin
              state  <= S_DUMMY1;
              busy   <= 1'b1;
              irq_id <= 4'd0;
              is_brk <= 1'b0;
              if (nmi_latch) begin
                cause <= CAUSE_NMI;
              end else if (irq_valid) begin
                cause  <= CAUSE_IRQ;
                irq_id <= irq_index;
              end else begin
                cause  <= CAUSE_IRQ;
                is_brk <= 1'b1;
              end
            end
          end
          S_DUMMY1: state <= S_DUMMY2;
          S_DUMMY2: begin
            state          <= S_PUSH_PCH;
            address_select <= 2'd1;
            memory_address <= stack_addr;
            sp_dec         <= 1'b1;
            push_sel       <= PUSH_PCH;
            rw             <= (cause == CAUSE_RES);
          end
          S_PUSH_PCH: begin
            state          <= S_PUSH_PCL;
            address_select <= 2'd1;
            memory_address <= stack_addr;
            sp_dec         <= 1'b1;
            push_sel       <= PUSH_PCL;
            rw             <= (cause == CAUSE_RES);
          end
          S_PUSH_PCL: begin
            state          <= S_PUSH_P;
            address_select <= 2'd1;
            memory_address <= stack_addr;
            sp_dec         <= 1'b1;
            push_sel       <= PUSH_P;
            rw             <= (cause == CAUSE_RES);
            b_flag         <= is_brk;
          end
          S_PUSH_P: begin
            state          <= S_VEC_LO;
            address_select <= 2'd1;
            memory_address <= vec_next;
            vec_addr       <= vec_next;
            if (hijack)
              cause <= CAUSE_NMI;
          end
          S_VEC_LO: begin
            state          <= S_VEC_HI;
            address_select <= 2'd1;
            memory_address <= vec_addr + ADDR_W'(1);
            vec_lo         <= data_in;
          end
          S_VEC_HI: begin
            state    <= S_DONE;
            pc_value <= ADDR_W'({data_in, vec_lo});
            pc_load  <= 1'b1;
            set_i    <= 1'b1;
          end
          S_DONE: begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            cause  <= CAUSE_NONE;
            irq_id <= 4'd0;
            is_brk <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb/tb_interrupt_sequencer.sv - scoreboard bench for interrupt_sequencer with directed entry sequences
module tb_interrupt_sequencer;
  import interrupt_sequencer_pkg::*;

  localparam int NIRQ = 4;
`ifdef IRQ_VECTOR_TABLE_EN
  localparam bit TABLE = 1'b1;
`else
  localparam bit TABLE = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] addr;
    logic        rw;
    logic [1:0]  ps;
    logic        sd;
    logic        b;
    logic [1:0]  cause;
    logic        ld;
    logic [15:0] pcv;
    logic        si;
    logic [3:0]  id;
  } ev_t;

  logic clk = 1'b0;
  logic res, rdy, sync, brk, nmi, i_flag;
  logic [NIRQ-1:0] irq;
  logic [7:0] sp, data_in;
  logic busy, rw, sp_dec, pc_load, set_i, b_flag;
  logic [15:0] memory_address, pc_value;
  logic [1:0] address_select, push_sel, cause;
  logic [3:0] irq_id;

  logic [7:0] sp_base;
  logic [7:0] push_cnt = 8'd0;
  int errors = 0;
  int checks = 0;
  ev_t exp_q[$];

  always #5 clk = ~clk;

  interrupt_sequencer #(.NUM_IRQ(NIRQ)) dut (
    .clk(clk), .res(res), .rdy(rdy), .sync(sync), .brk(brk), .nmi(nmi),
    .irq(irq), .i_flag(i_flag), .sp(sp), .data_in(data_in),
    .busy(busy), .memory_address(memory_address), .address_select(address_select),
    .rw(rw), .push_sel(push_sel), .sp_dec(sp_dec), .pc_load(pc_load),
    .pc_value(pc_value), .set_i(set_i), .b_flag(b_flag), .cause(cause), .irq_id(irq_id)
  );

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    case (a)
      16'hFFFA: mem_rd = 8'hBC;
      16'hFFFB: mem_rd = 8'h9A;
      16'hFFFC: mem_rd = 8'h34;
      16'hFFFD: mem_rd = 8'h12;
      16'hFFFE: mem_rd = 8'h78;
      16'hFFFF: mem_rd = 8'h56;
      default:  mem_rd = 8'h00;
    endcase
  endfunction

  function automatic logic [15:0] irq_vec(input int k);
    irq_vec = TABLE ? 16'hFFFE - 16'(2 * (k + 1)) : 16'hFFFE;
  endfunction

  assign data_in = mem_rd(memory_address);
  assign sp = sp_base - push_cnt;

  always @(posedge clk)
    if (!res && rdy && sp_dec) push_cnt <= push_cnt + 8'd1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic check_reset(input string name);
    check(name, {busy, cause, rw, address_select, pc_load, push_sel, sp_dec, set_i, b_flag,
                 irq_id, memory_address, pc_value},
          {1'b1, CAUSE_RES, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0, 16'd0});
  endtask

  task automatic q_seq(input logic [1:0] c0, input logic prw, input logic [7:0] sp0, input logic bf,
                       input logic [1:0] c1, input logic [15:0] vec, input logic [3:0] id, input int n);
    ev_t e [6];
    for (int k = 0; k < 3; k++) begin
      e[k] = '0;
      e[k].addr = {8'h01, sp0 - 8'(k)};
      e[k].rw = prw;
      e[k].ps = 2'(k + 1);
      e[k].sd = 1'b1;
      e[k].cause = c0;
      e[k].id = id;
    end
    e[2].b = bf;
    for (int k = 3; k < 5; k++) begin
      e[k] = '0;
      e[k].addr = vec + 16'(k - 3);
      e[k].rw = 1'b1;
      e[k].cause = c1;
      e[k].id = id;
    end
    e[5] = '0;
    e[5].rw = 1'b1;
    e[5].cause = c1;
    e[5].ld = 1'b1;
    e[5].pcv = {mem_rd(vec + 16'd1), mem_rd(vec)};
    e[5].si = 1'b1;
    e[5].id = id;
    for (int k = 0; k < n; k++) exp_q.push_back(e[k]);
  endtask

  // Called at posedge+2; the next posedge is the entry edge.
  task automatic run_seq(input int stall_at, input int nmi_at, input int res_at,
                         input logic [7:0] sp0, output int cyc);
    sync = 1'b1;
    @(posedge clk);
    #2;
    sync = 1'b0;
    brk = 1'b0;
    irq = '0;
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      cyc++;
      if (stall_at >= 0 && i > stall_at && i <= stall_at + 3)
        check("stall_frozen", {memory_address, rw, push_sel, sp_dec, busy},
              {8'h01, sp0, 1'b0, PUSH_PCH, 1'b1, 1'b1});
      #1;
      if (i == stall_at) rdy = 1'b0;
      if (i == stall_at + 3) rdy = 1'b1;
      if (i == nmi_at) nmi = 1'b1;
      if (i == res_at) begin
        res = 1'b1;
        break;
      end
    end
    if (res_at < 0) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Called just after a negedge with res high.
  task automatic reset_seq(input string name);
    int cyc;
    cyc = 0;
    sp_base = 8'hFD + push_cnt;
    q_seq(CAUSE_RES, 1'b1, 8'hFD, 1'b0, CAUSE_RES, 16'hFFFC, 4'd0, 6);
    #1 res = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      cyc++;
    end
    check(name, 64'(cyc), 64'd8);
    @(posedge clk);
    #2;
  endtask

  task automatic expect_idle(input string name);
    sync = 1'b1;
    @(posedge clk);
    #2;
    sync = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check(name, {63'd0, busy}, 64'd0);
    end
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    ev_t act, e;
    forever begin
      @(negedge clk);
      if (!res && rdy && (address_select == 2'd1 || pc_load)) begin
        act.addr  = pc_load ? 16'h0 : memory_address;
        act.rw    = rw;
        act.ps    = push_sel;
        act.sd    = sp_dec;
        act.b     = b_flag;
        act.cause = cause;
        act.ld    = pc_load;
        act.pcv   = pc_load ? pc_value : 16'h0;
        act.si    = set_i;
        act.id    = irq_id;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bus_event unexpected: got %h want none", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL bus_event: got %h want %h", act, e);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin : stimulus
    int cyc;
    res = 1'b1; rdy = 1'b1; sync = 1'b0; brk = 1'b0; nmi = 1'b0;
    irq = '0; i_flag = 1'b0; sp_base = 8'hFD;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset_values");
    reset_seq("res_busy_cycles");

    irq = 4'b0001;
    sp_base = 8'hF0 + push_cnt;
    q_seq(CAUSE_IRQ, 1'b0, 8'hF0, 1'b0, CAUSE_IRQ, irq_vec(0), 4'd0, 6);
    run_seq(-1, -1, -1, 8'hF0, cyc);
    check("irq0_busy_cycles", 64'(cyc), 64'd8);

    irq = 4'b0001;
    i_flag = 1'b1;
    expect_idle("masked_no_entry");
    i_flag = 1'b0;
    sp_base = 8'hE0 + push_cnt;
    q_seq(CAUSE_IRQ, 1'b0, 8'hE0, 1'b0, CAUSE_IRQ, irq_vec(0), 4'd0, 6);
    run_seq(-1, -1, -1, 8'hE0, cyc);
    check("unmasked_busy_cycles", 64'(cyc), 64'd8);

    irq = 4'b0001;
    sp_base = 8'hD0 + push_cnt;
    q_seq(CAUSE_IRQ, 1'b0, 8'hD0, 1'b0, CAUSE_NMI, 16'hFFFA, 4'd0, 6);
    run_seq(-1, 4, -1, 8'hD0, cyc);
    check("hijack_busy_cycles", 64'(cyc), 64'd8);
    expect_idle("nmi_no_retrigger");
    nmi = 1'b0;

    irq = 4'b1010;
    sp_base = 8'hC8 + push_cnt;
    q_seq(CAUSE_IRQ, 1'b0, 8'hC8, 1'b0, CAUSE_IRQ, irq_vec(1), 4'd1, 6);
    run_seq(-1, -1, -1, 8'hC8, cyc);
    check("irq1_busy_cycles", 64'(cyc), 64'd8);

    brk = 1'b1;
    sp_base = 8'hB0 + push_cnt;
    q_seq(CAUSE_IRQ, 1'b0, 8'hB0, 1'b1, CAUSE_IRQ, 16'hFFFE, 4'd0, 6);
    run_seq(-1, -1, -1, 8'hB0, cyc);
    check("brk_busy_cycles", 64'(cyc), 64'd8);

    irq = 4'b0001;
    sp_base = 8'hA0 + push_cnt;
    q_seq(CAUSE_IRQ, 1'b0, 8'hA0, 1'b0, CAUSE_IRQ, irq_vec(0), 4'd0, 6);
    run_seq(3, -1, -1, 8'hA0, cyc);
    check("stall_busy_cycles", 64'(cyc), 64'd11);

    brk = 1'b1;
    sp_base = 8'h90 + push_cnt;
    q_seq(CAUSE_IRQ, 1'b0, 8'h90, 1'b1, CAUSE_IRQ, 16'hFFFE, 4'd0, 4);
    run_seq(-1, -1, 6, 8'h90, cyc);
    #1;
    check_reset("abort_reset_values");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_pc_load", {62'd0, pc_load, busy}, 64'd1);
    end
    reset_seq("rerun_res_busy_cycles");

    repeat (4) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Parametrised successor to the single-source opcode sequencer; takes over the bus for the RES, NMI, IRQ and BRK entry sequences that the opcode FSM leaves unhandled.
- Sits beside instruction_decode. Holds the decoder via busy, drives stack pushes through the data buffer mux, fetches the 16-bit vector and loads it into the PC.
- Generalised to NUM_IRQ maskable sources with fixed priority, plus NMI hijack of an IRQ or BRK in flight.

Parameters:
- ADDR_W, 16, address width.
- NUM_IRQ, 1, maskable IRQ lines (1..16).
- STACK_PAGE, 8'h01, high byte of stack addresses.
- VEC_NMI, 16'hFFFA, NMI vector low-byte address.
- VEC_RES, 16'hFFFC, RES vector low-byte address.
- VEC_IRQ, 16'hFFFE, IRQ/BRK vector low-byte address.

Ports:
- clk  in  1  system clock; all logic on posedge.
- res  in  1  reset; asynchronous, active-high.
- rdy  in  1  low freezes state and all outputs.
- sync  in  1  decoder is at an opcode-fetch boundary.
- brk  in  1  decoder has decoded BRK; valid with sync.
- nmi  in  1  non-maskable request, rising-edge sensitive.
- irq  in  NUM_IRQ  maskable requests, level, active-high.
- i_flag  in  1  processor I flag.
- sp  in  8  current stack pointer.
- data_in  in  8  data bus read value.
- busy  out  1  decoder must hold while high.
- memory_address  out  ADDR_W  bus address when address_select=1.
- address_select  out  2  0=PC, 1=memory_address.
- rw  out  1  1=read, 0=write.
- push_sel  out  2  data buffer source: 00 none, 01 PCH, 10 PCL, 11 P.
- sp_dec  out  1  decrement SP at end of cycle.
- pc_load  out  1  load PC from pc_value.
- pc_value  out  ADDR_W  vector value.
- set_i  out  1  set the I flag.
- b_flag  out  1  B bit to merge into pushed P.
- cause  out  2  0 none, 1 RES, 2 NMI, 3 IRQ/BRK.
- irq_id  out  4  index of the serviced IRQ line.

Behaviour:
- Async reset values:
  - busy=1, cause=1; a reset sequence is pending.
  - rw=1.
  - All other outputs 0.
  - NMI edge latch cleared, nmi_prev=0, state S_IDLE.
- Registered outputs. States, in order: S_IDLE, S_DUMMY1, S_DUMMY2, S_PUSH_PCH, S_PUSH_PCL, S_PUSH_P, S_VEC_LO, S_VEC_HI, S_DONE.
- Event selection:
  - After res falls, the first posedge leaves S_IDLE for S_DUMMY1 with cause=RES, regardless of sync.
  - Otherwise an event is taken only when sync=1 in S_IDLE.
  - Priority: pending NMI latch, then IRQ (only if i_flag=0; lowest asserted index wins), then brk.
  - cause and irq_id are latched at entry.
- NMI: latch sets on a sampled nmi 0->1 transition, whether idle or busy. It clears on the posedge leaving S_VEC_LO of an NMI vector fetch. Holding nmi high does not retrigger.
- DUMMY1 and DUMMY2: address_select=0, rw=1.
- PUSH_PCH, PUSH_PCL, PUSH_P:
  - memory_address={STACK_PAGE,sp}; sp_dec=1; push_sel=01/10/11 respectively.
  - rw=0, except cause=RES, where rw=1 (reads, SP still decremented 3).
- b_flag=1 only during PUSH_P for a BRK entry.
- NMI hijack: if the NMI latch is set before the posedge entering S_VEC_LO during an IRQ/BRK sequence, cause becomes NMI and VEC_NMI is used; b_flag already pushed is unchanged.
- VEC_LO: memory_address=vector, rw=1; data_in captured at exit.
- VEC_HI: memory_address=vector+1 (wraps modulo 2^ADDR_W); data_in captured at exit.
- DONE:
  - pc_load=1, pc_value={hi,lo}, set_i=1; busy=1 this cycle.
  - Next cycle S_IDLE, busy=0, cause=0.
- Latency: exactly 8 cycles of busy from the entry posedge.
- rdy=0: no state advance, outputs held, latch still sets on nmi edges.
- res asserted mid-sequence aborts immediately to reset values; no PC load.

Optional Feature:
- Macro IRQ_VECTOR_TABLE_EN.
- When defined, IRQ source k vectors at VEC_IRQ-2*(k+1), forming a descending per-source table. BRK still uses VEC_IRQ.
- When undefined, all IRQ sources share VEC_IRQ.

Decomposition:
- Shared package header holds:
  - state encodings;
  - cause codes (CAUSE_NONE, CAUSE_RES, CAUSE_NMI, CAUSE_IRQ);
  - push_sel codes (PUSH_NONE, PUSH_PCH, PUSH_PCL, PUSH_P);
  - default vector constants.
- One natural sub-module: irq_priority_encoder. Combinational masked lowest-index select over NUM_IRQ lines, returning valid and index.

Test Plan:
- Reset release, memory[FFFC]=34, [FFFD]=12 -> 8 busy cycles, three reads at 01FD/01FC/01FB with sp=FD, pc_load with 1234, set_i=1.
- irq[0]=1, i_flag=0, sync pulse, sp=F0 -> writes at 01F0/01EF/01EE with push_sel 01/10/11, vector FFFE/FFFF, cause=3.
- irq=1, i_flag=1, sync -> no entry, busy stays 0; clear i_flag, next sync -> entry.
- IRQ entry, nmi rises during PUSH_PCL -> VEC_NMI FFFA used, cause=2, NMI latch clears; nmi held high, next sync -> no retrigger.
- NUM_IRQ=4, irq=4'b1010, IRQ_VECTOR_TABLE_EN -> irq_id=1, vector FFFA, FFFB; brk with sync -> b_flag=1 during PUSH_P.
- rdy low for 3 cycles in PUSH_PCH -> outputs frozen, busy stretches to 11 cycles; res pulsed in VEC_LO -> async return to reset values, no pc_load.
